brownout_seq_ctrl: RTL and testbench
====================================

Name: brownout_seq_ctrl

Overview:
Digital sequencer for the brown-out detector macro. Owns the detector's ena and otrip/vtrip trip codes, and blanks the comparator during power-up and trip-code changes. Debounces brout_filt and vunder into a system reset (sys_rstb) with a programmable post-recovery hold. Keeps sticky status flags and an event counter for firmware. Sits in the always-on dvdd domain, clocked by the detector's osc_ck.

Parameters:
SETTLE_CYC, 64, blanking cycles after ena rise or a trip-code change (>=1)
DEB_CYC, 4, consecutive synchronized brout cycles that declare a brownout (>=2)
HOLD_CYC, 1024, cycles sys_rstb stays low after brout clears (>=1)
CNT_W, 8, brownout event counter width

Ports:
osc_ck  in  1  clock
rstb  in  1  reset, asynchronous, active-low
en_req  in  1  firmware enable for the detector
otrip_cfg  in  3  requested otrip code
vtrip_cfg  in  3  requested vtrip code
cfg_valid  in  1  trip-code update request
cfg_ready  out  1  update accepted when cfg_valid & cfg_ready
brout_filt  in  1  detector brownout output (async)
vunder  in  1  detector undervoltage output (async)
clr_sticky  in  1  clears bo_sticky and vu_sticky
ena  out  1  detector enable
otrip  out  3  detector otrip code
vtrip  out  3  detector vtrip code
sys_rstb  out  1  system reset, active-low
bo_sticky  out  1  brownout occurred
vu_sticky  out  1  undervoltage occurred
bo_count  out  CNT_W  saturating brownout event count
state  out  3  FSM state, debug

Behaviour:
- Reset (rstb=0, async): state=OFF, ena=0, otrip=3'b111, vtrip=3'b111, sys_rstb=0, bo_sticky=0, vu_sticky=0, bo_count=0, timer=0, deb=0, first_up=0.
- brout_filt and vunder pass through 2-flop synchronizers (brout_s, vunder_s). Sync latency is 2 cycles. All outputs are registered except cfg_ready.
- sys_rstb is held 0 until the first MONITOR entry (first_up=1). After that it is 0 only in BROWNOUT and HOLD.
- States: OFF=0, SETTLE=1, MONITOR=2, BROWNOUT=3, HOLD=4.
- OFF: ena=0. If en_req=1, go to SETTLE with timer=SETTLE_CYC-1; ena=1 from the next cycle.
- SETTLE: ena=1 and brout_s is ignored. Timer decrements; at 0, go to MONITOR. If en_req=0, go to OFF immediately.
- MONITOR:
  - deb increments while brout_s=1 and clears when brout_s=0.
  - When deb reaches DEB_CYC-1 with brout_s=1: go to BROWNOUT, set bo_sticky, bo_count+1 saturating at all-ones.
  - A vunder_s rising edge sets vu_sticky. vunder_s is ignored in all other states.
- cfg_ready=1 in OFF, and in MONITOR when deb=0 and en_req=1.
- On a cfg handshake:
  - otrip/vtrip latch otrip_cfg/vtrip_cfg on the next edge.
  - In MONITOR, go to SETTLE with timer=SETTLE_CYC-1.
  - In OFF, stay in OFF.
- MONITOR priority, highest first: en_req=0 (go to OFF, deb=0), then brownout detect, then cfg handshake.
- BROWNOUT: sys_rstb=0 and en_req is ignored. When brout_s=0, go to HOLD with timer=HOLD_CYC-1.
- HOLD: sys_rstb=0.
  - brout_s=1: back to BROWNOUT. bo_count does not increment; it is the same event.
  - Timer 0 with en_req=1: go to MONITOR, deb=0, sys_rstb=1 next cycle.
  - Timer 0 with en_req=0: go to OFF.
- clr_sticky clears both sticky flags. A set in the same cycle wins. bo_count is cleared only by rstb.
- rstb assertion mid-operation aborts any state: ena=0 and sys_rstb=0 asynchronously.
- Timer width is clog2(max(SETTLE_CYC,HOLD_CYC))+1 bits. No wrap: the timer only decrements while nonzero.

Test Plan:
- Power-up: rstb release, en_req=1 at cycle 5 → ena=1 at cycle 6; sys_rstb stays 0 until MONITOR, 64 cycles later; brout_filt pulses during SETTLE have no effect.
- Debounce: in MONITOR, brout_filt=1 for 3 cycles then 0 → no event. brout_filt=1 for 4 cycles (+2 sync) → BROWNOUT, sys_rstb=0, bo_sticky=1, bo_count=1.
- Hold and re-trip: brout clears → sys_rstb stays 0 exactly 1024 cycles, then 1. A repeat brout during HOLD → BROWNOUT with bo_count unchanged and the hold timer restarting on clear.
- Trip-code update: in MONITOR, cfg_valid with otrip_cfg=3'b010, vtrip_cfg=3'b101 → handshake, otrip/vtrip update next cycle, 64-cycle blanking, return to MONITOR, sys_rstb stays 1.
- Counter/sticky: 300 debounced brownouts → bo_count=255. clr_sticky coincident with a new event → bo_sticky remains 1. A vunder rising edge in MONITOR → vu_sticky=1.
- Priority and abort: en_req=0 coincident with debounce completion → OFF, no count. rstb asserted in HOLD → ena=0, sys_rstb=0 immediately, all counters at reset values.

Source files
------------

// File: rtl/brownout_seq_ctrl_if.sv
// brownout_seq_ctrl_if: firmware control, detector I/O and status bundle of the brown-out sequencer.
interface brownout_seq_ctrl_if #(parameter int CNT_W = 8);
   logic             en_req;
   logic [2:0]       otrip_cfg;
   logic [2:0]       vtrip_cfg;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             brout_filt;
   logic             vunder;
   logic             clr_sticky;
   logic             ena;
   logic [2:0]       otrip;
   logic [2:0]       vtrip;
   logic             sys_rstb;
   logic             bo_sticky;
   logic             vu_sticky;
   logic [CNT_W-1:0] bo_count;
   logic [2:0]       state;
   modport master (output en_req, otrip_cfg, vtrip_cfg, cfg_valid, brout_filt, vunder, clr_sticky,
                   input  cfg_ready, ena, otrip, vtrip, sys_rstb, bo_sticky, vu_sticky, bo_count, state);
   modport slave  (input  en_req, otrip_cfg, vtrip_cfg, cfg_valid, brout_filt, vunder, clr_sticky,
                   output cfg_ready, ena, otrip, vtrip, sys_rstb, bo_sticky, vu_sticky, bo_count, state);
endinterface

// File: rtl/brownout_seq_ctrl.sv
// brownout_seq_ctrl: brown-out detector sequencer with comparator blanking, debounce,
// post-recovery reset hold, sticky status and saturating event count.
module brownout_seq_ctrl #(
   parameter int SETTLE_CYC = 64,
   parameter int DEB_CYC    = 4,
   parameter int HOLD_CYC   = 1024,
   parameter int CNT_W      = 8
) (
   input  logic                   osc_ck,
   input  logic                   rstb,
   brownout_seq_ctrl_if.slave     bus
);
   typedef enum logic [2:0] {OFF = 3'd0, SETTLE = 3'd1, MONITOR = 3'd2, BROWNOUT = 3'd3, HOLD = 3'd4} state_t;
   localparam int TW = $clog2(SETTLE_CYC > HOLD_CYC ? SETTLE_CYC : HOLD_CYC) + 1;
   localparam int DW = $clog2(DEB_CYC);
   state_t           r_state, w_state;
   logic [TW-1:0]    r_timer, w_timer;
   logic [DW-1:0]    r_deb, w_deb;
   logic             r_br_m, r_br_s, r_vu_m, r_vu_s, r_vu_d;
   logic             r_first_up, r_ena, r_sys_rstb, r_bo_sticky, r_vu_sticky;
   logic [2:0]       r_otrip, r_vtrip;
   logic [CNT_W-1:0] r_bo_count;
   logic             w_hs, w_bo_evt, w_vu_evt, w_first_up;
   assign bus.cfg_ready = (r_state == OFF) || (r_state == MONITOR && r_deb == '0 && bus.en_req);
   assign w_hs          = bus.cfg_valid && bus.cfg_ready;
   assign w_bo_evt      = r_state == MONITOR && bus.en_req && r_br_s && r_deb == DW'(DEB_CYC - 1);
   assign w_vu_evt      = r_state == MONITOR && r_vu_s && !r_vu_d;
   assign w_first_up    = r_first_up || w_state == MONITOR;
   assign bus.state     = r_state;
   assign bus.ena       = r_ena;
   assign bus.otrip     = r_otrip;
   assign bus.vtrip     = r_vtrip;
   assign bus.sys_rstb  = r_sys_rstb;
   assign bus.bo_sticky = r_bo_sticky;
   assign bus.vu_sticky = r_vu_sticky;
   assign bus.bo_count  = r_bo_count;
   always_comb begin
      w_state = r_state;
      w_timer = (r_timer != '0) ? r_timer - TW'(1) : r_timer;
      w_deb   = '0;
      case (r_state)
         OFF: if (!w_hs && bus.en_req) begin
            w_state = SETTLE;
            w_timer = TW'(SETTLE_CYC - 1);
         end
         SETTLE: w_state = !bus.en_req ? OFF : (r_timer == '0) ? MONITOR : SETTLE;
         MONITOR: begin
            // enable drop beats a completing debounce, which beats a trip-code update
            if (!bus.en_req) w_state = OFF;
            else if (w_bo_evt) w_state = BROWNOUT;
            else if (w_hs) begin
               w_state = SETTLE;
               w_timer = TW'(SETTLE_CYC - 1);
            end else w_deb = r_br_s ? r_deb + DW'(1) : '0;
         end
         BROWNOUT: if (!r_br_s) begin
            w_state = HOLD;
            w_timer = TW'(HOLD_CYC - 1);
         end
         HOLD: w_state = r_br_s ? BROWNOUT : (r_timer != '0) ? HOLD : bus.en_req ? MONITOR : OFF;
         default: w_state = OFF;
      endcase
   end
   always_ff @(posedge osc_ck or negedge rstb)
      if (!rstb) r_state <= OFF;
      else r_state <= w_state;
   always_ff @(posedge osc_ck or negedge rstb)
      if (!rstb) begin
         r_timer     <= '0;
         r_deb       <= '0;
         r_br_m      <= 1'b0;
         r_br_s      <= 1'b0;
         r_vu_m      <= 1'b0;
         r_vu_s      <= 1'b0;
         r_vu_d      <= 1'b0;
         r_first_up  <= 1'b0;
         r_ena       <= 1'b0;
         r_sys_rstb  <= 1'b0;
         r_bo_sticky <= 1'b0;
         r_vu_sticky <= 1'b0;
         r_otrip     <= 3'b111;
         r_vtrip     <= 3'b111;
         r_bo_count  <= '0;
      end else begin
         r_timer     <= w_timer;
         r_deb       <= w_deb;
         r_br_m      <= bus.brout_filt;
         r_br_s      <= r_br_m;
         r_vu_m      <= bus.vunder;
         r_vu_s      <= r_vu_m;
         r_vu_d      <= r_vu_s;
         r_first_up  <= w_first_up;
         r_ena       <= w_state != OFF;
         r_sys_rstb  <= w_first_up && w_state != BROWNOUT && w_state != HOLD;
         r_bo_sticky <= w_bo_evt || (r_bo_sticky && !bus.clr_sticky);
         r_vu_sticky <= w_vu_evt || (r_vu_sticky && !bus.clr_sticky);
         r_otrip     <= w_hs ? bus.otrip_cfg : r_otrip;
         r_vtrip     <= w_hs ? bus.vtrip_cfg : r_vtrip;
         r_bo_count  <= r_bo_count + CNT_W'(w_bo_evt && r_bo_count != '1);
      end
endmodule

// File: tb/tb_brownout_seq_ctrl.sv
// tb_brownout_seq_ctrl: directed table and sequences on a default-parameter instance, then
// randomized and saturation runs on a short-timer instance against a cycle-level model.
module tb_brownout_seq_ctrl;
   localparam int SS = 4, SD = 4, SH = 8;
   logic clk = 1'b0, rstb_b = 1'b0, rstb_s = 1'b0;
   int   n_vec = 0, n_err = 0;
   brownout_seq_ctrl_if #(.CNT_W(8)) bif ();
   brownout_seq_ctrl_if #(.CNT_W(8)) sif ();
   brownout_seq_ctrl u_big (.osc_ck(clk), .rstb(rstb_b), .bus(bif.slave));
   brownout_seq_ctrl #(.SETTLE_CYC(SS), .DEB_CYC(SD), .HOLD_CYC(SH), .CNT_W(8))
      u_small (.osc_ck(clk), .rstb(rstb_s), .bus(sif.slave));
   always #5 clk = ~clk;

   typedef struct { bit en; bit br; int n; int st; bit ena; bit sys; bit bos; int cnt; } vec_t;
   vec_t tbl[11];

   // reference model for the short-timer instance: mode 0..4, deadline-based timers
   int m_mode, m_run, m_cnt, m_ot, m_vt, m_cyc, m_deadline;
   bit m_first, m_bo, m_vu;
   bit br_q[$], vu_q[$];
   bit r_en, r_br, r_vu;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return m_mode == 0 || (m_mode == 2 && m_run == 0 && sif.en_req);
   endfunction

   task automatic m_reset();
      m_mode = 0; m_run = 0; m_cnt = 0; m_ot = 7; m_vt = 7; m_cyc = 0; m_deadline = 0;
      m_first = 0; m_bo = 0; m_vu = 0;
      br_q = '{0, 0};
      vu_q = '{0, 0, 0};
   endtask

   task automatic m_step();
      bit bs, vs, vp, hs, bo_evt, vu_evt, en;
      int nmode, nrun;
      en = sif.en_req;
      bs = br_q.pop_front(); br_q.push_back(sif.brout_filt);
      vp = vu_q[0]; vs = vu_q[1]; void'(vu_q.pop_front()); vu_q.push_back(sif.vunder);
      m_cyc++;
      hs = sif.cfg_valid && m_ready();
      bo_evt = m_mode == 2 && en && bs && m_run == SD - 1;
      vu_evt = m_mode == 2 && vs && !vp;
      nmode = m_mode; nrun = 0;
      if (m_mode == 0) begin
         if (!hs && en) begin nmode = 1; m_deadline = m_cyc + SS; end
      end else if (m_mode == 1) begin
         if (!en) nmode = 0; else if (m_cyc >= m_deadline) nmode = 2;
      end else if (m_mode == 2) begin
         if (!en) nmode = 0;
         else if (bo_evt) nmode = 3;
         else if (hs) begin nmode = 1; m_deadline = m_cyc + SS; end
         else nrun = bs ? m_run + 1 : 0;
      end else if (m_mode == 3) begin
         if (!bs) begin nmode = 4; m_deadline = m_cyc + SH; end
      end else begin
         if (bs) nmode = 3; else if (m_cyc >= m_deadline) nmode = en ? 2 : 0;
      end
      if (hs) begin m_ot = sif.otrip_cfg; m_vt = sif.vtrip_cfg; end
      m_bo = bo_evt || (m_bo && !sif.clr_sticky);
      m_vu = vu_evt || (m_vu && !sif.clr_sticky);
      if (bo_evt && m_cnt < 255) m_cnt++;
      if (nmode == 2) m_first = 1;
      m_mode = nmode; m_run = nrun;
   endtask

   always @(posedge clk) if (rstb_s) m_step();

   task automatic s_check();
      chk("s_state", sif.state, m_mode);
      chk("s_ena", sif.ena, m_mode != 0);
      chk("s_sys_rstb", sif.sys_rstb, m_first && m_mode != 3 && m_mode != 4);
      chk("s_otrip", sif.otrip, m_ot);
      chk("s_vtrip", sif.vtrip, m_vt);
      chk("s_bo_sticky", sif.bo_sticky, m_bo);
      chk("s_vu_sticky", sif.vu_sticky, m_vu);
      chk("s_bo_count", sif.bo_count, m_cnt);
   endtask

   task automatic s_apply(input bit en, br, vu, cv, clr, input logic [2:0] oc, vc);
      sif.en_req = en; sif.brout_filt = br; sif.vunder = vu; sif.cfg_valid = cv;
      sif.clr_sticky = clr; sif.otrip_cfg = oc; sif.vtrip_cfg = vc;
      #1 chk("s_cfg_ready", sif.cfg_ready, m_ready());
      @(negedge clk);
      s_check();
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic b_stat(input string tag, input int st, input bit ena, sys, bos, input int cnt);
      chk({tag, "_state"}, bif.state, st);
      chk({tag, "_ena"}, bif.ena, ena);
      chk({tag, "_sys_rstb"}, bif.sys_rstb, sys);
      chk({tag, "_bo_sticky"}, bif.bo_sticky, bos);
      chk({tag, "_bo_count"}, bif.bo_count, cnt);
   endtask

   initial begin
      int w;
      tbl[0]  = '{1, 0, 1,    1, 1, 0, 0, 0};
      tbl[1]  = '{1, 1, 10,   1, 1, 0, 0, 0};
      tbl[2]  = '{1, 0, 53,   1, 1, 0, 0, 0};
      tbl[3]  = '{1, 0, 1,    2, 1, 1, 0, 0};
      tbl[4]  = '{1, 1, 3,    2, 1, 1, 0, 0};
      tbl[5]  = '{1, 0, 6,    2, 1, 1, 0, 0};
      tbl[6]  = '{1, 1, 6,    3, 1, 0, 1, 1};
      tbl[7]  = '{1, 1, 10,   3, 1, 0, 1, 1};
      tbl[8]  = '{1, 0, 3,    4, 1, 0, 1, 1};
      tbl[9]  = '{1, 0, 1023, 4, 1, 0, 1, 1};
      tbl[10] = '{1, 0, 1,    2, 1, 1, 1, 1};
      {bif.en_req, bif.brout_filt, bif.vunder, bif.cfg_valid, bif.clr_sticky} = '0;
      {sif.en_req, sif.brout_filt, sif.vunder, sif.cfg_valid, sif.clr_sticky} = '0;
      bif.otrip_cfg = 3'd0; bif.vtrip_cfg = 3'd0; sif.otrip_cfg = 3'd0; sif.vtrip_cfg = 3'd0;
      tick(2);
      b_stat("rst", 0, 0, 0, 0, 0);
      chk("rst_otrip", bif.otrip, 7);
      chk("rst_vtrip", bif.vtrip, 7);
      chk("rst_vu_sticky", bif.vu_sticky, 0);
      rstb_b = 1'b1;
      tick(4);
      b_stat("idle", 0, 0, 0, 0, 0);
      chk("idle_cfg_ready", bif.cfg_ready, 1);
      for (int i = 0; i < 11; i++) begin
         bif.en_req = tbl[i].en; bif.brout_filt = tbl[i].br;
         tick(tbl[i].n);
         b_stat($sformatf("tbl%0d", i), tbl[i].st, tbl[i].ena, tbl[i].sys, tbl[i].bos, tbl[i].cnt);
      end
      // re-trip during hold: same event, hold restarts
      bif.brout_filt = 1; tick(6); b_stat("rt_bo", 3, 1, 0, 1, 2);
      bif.brout_filt = 0; tick(3); tick(100); b_stat("rt_hold", 4, 1, 0, 1, 2);
      bif.brout_filt = 1; tick(3); b_stat("rt_again", 3, 1, 0, 1, 2);
      bif.brout_filt = 0; tick(3); tick(1023); b_stat("rt_hold2", 4, 1, 0, 1, 2);
      tick(1); b_stat("rt_mon", 2, 1, 1, 1, 2);
      // trip-code update with blanking
      bif.cfg_valid = 1; bif.otrip_cfg = 3'b010; bif.vtrip_cfg = 3'b101;
      #1 chk("cfg_ready_mon", bif.cfg_ready, 1);
      tick(1); bif.cfg_valid = 0;
      chk("cfg_otrip", bif.otrip, 3'b010);
      chk("cfg_vtrip", bif.vtrip, 3'b101);
      #1 chk("cfg_ready_settle", bif.cfg_ready, 0);
      b_stat("cfg_settle", 1, 1, 1, 1, 2);
      tick(63); b_stat("cfg_settle_end", 1, 1, 1, 1, 2);
      tick(1); b_stat("cfg_mon", 2, 1, 1, 1, 2);
      // sticky clear, then clear coincident with a new event
      bif.clr_sticky = 1; tick(1); bif.clr_sticky = 0; b_stat("clr", 2, 1, 1, 0, 2);
      bif.brout_filt = 1; tick(5); bif.clr_sticky = 1; tick(1); bif.clr_sticky = 0;
      b_stat("clr_evt", 3, 1, 0, 1, 3);
      bif.brout_filt = 0; tick(3); tick(1024); b_stat("clr_mon", 2, 1, 1, 1, 3);
      // undervoltage edge
      chk("vu_before", bif.vu_sticky, 0);
      bif.vunder = 1; tick(4); chk("vu_set", bif.vu_sticky, 1);
      bif.vunder = 0; bif.clr_sticky = 1; tick(1); bif.clr_sticky = 0;
      chk("vu_clr", bif.vu_sticky, 0);
      // enable drop coincident with debounce completion
      bif.brout_filt = 1; tick(5); bif.en_req = 0; tick(1);
      b_stat("endrop", 0, 0, 1, 0, 3);
      #1 chk("off_cfg_ready", bif.cfg_ready, 1);
      // abort from hold by async reset
      bif.brout_filt = 0; bif.en_req = 1; tick(1); b_stat("re_settle", 1, 1, 1, 0, 3);
      tick(64); b_stat("re_mon", 2, 1, 1, 0, 3);
      bif.brout_filt = 1; tick(6); b_stat("ab_bo", 3, 1, 0, 1, 4);
      bif.brout_filt = 0; tick(3); tick(10); b_stat("ab_hold", 4, 1, 0, 1, 4);
      #3 rstb_b = 0;
      #1 b_stat("abort", 0, 0, 0, 0, 0);
      chk("abort_otrip", bif.otrip, 7);
      @(negedge clk); rstb_b = 1; bif.en_req = 0;
      // randomized run on the short-timer instance
      m_reset();
      rstb_s = 1;
      r_en = 1; r_br = 0; r_vu = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 63) == 0) r_en = 0;
         else if (!r_en && $urandom_range(0, 3) == 0) r_en = 1;
         if ($urandom_range(0, 5) == 0) r_br = !r_br;
         if ($urandom_range(0, 11) == 0) r_vu = !r_vu;
         s_apply(r_en, r_br, r_vu, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      // saturate the event counter
      w = 0;
      do begin s_apply(1, 0, 0, 0, 0, 0, 0); w++; end while (m_mode != 2 && w < 300);
      chk("sat_start", sif.state, 2);
      for (int k = 0; k < 300; k++) begin
         repeat (8) s_apply(1, 1, 0, 0, 0, 0, 0);
         w = 0;
         do begin s_apply(1, 0, 0, 0, 0, 0, 0); w++; end while (m_mode != 2 && w < 100);
         chk("sat_recover", sif.state, 2);
      end
      chk("sat_count", sif.bo_count, 255);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
